// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state and control-word types for the pipeline controller
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_RUN     = 3'd1,
      ST_LDSTALL = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_HALT    = 3'd4
   } pipe_ctrl_state_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_bubble;
   } pipe_ctl_t;

   // Bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble
   localparam pipe_ctl_t CTL_INIT    = 5'b00111;
   localparam pipe_ctl_t CTL_BRANCH  = 5'b11111;
   localparam pipe_ctl_t CTL_HALTREQ = 5'b00110;
   localparam pipe_ctl_t CTL_STALL   = 5'b00011;
   localparam pipe_ctl_t CTL_NORMAL  = 5'b11010;
   localparam pipe_ctl_t CTL_DRAIN   = 5'b00011;
   localparam pipe_ctl_t CTL_HALT    = 5'b00000;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - free-running stall and branch-flush event counters
module pipe_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_inc,
   input  logic        flush_inc,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall_inc) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush_inc) flush_count_d  = flush_count_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule

// File: rtl/sys_defs.vh
// rtl/sys_defs.vh - default pipeline controller sizing constants
`ifndef SYS_DEFS_VH
`define SYS_DEFS_VH

`define PIPE_DEFAULT_MAX_STALL    3
`define PIPE_DEFAULT_DRAIN_CYCLES 3

`endif

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline hazard/halt controller (Mealy FSM)
// Optional perf counters enabled by PIPE_PERF_CNT_EN.
`include "sys_defs.vh"

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_STALL    = `PIPE_DEFAULT_MAX_STALL,
   parameter int DRAIN_CYCLES = `PIPE_DEFAULT_DRAIN_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_id_valid_inst,
   input  logic        id_stall_flag,
   input  logic        id_illegal,
   input  logic        id_is_ebreak,
   input  logic        ex_take_branch,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_en,
   output logic        id_ex_bubble,
   output logic        halted,
   output logic        halt_err
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam int SCW = ($clog2(MAX_STALL + 1) > 1) ? $clog2(MAX_STALL + 1) : 1;
   localparam int DCW = ($clog2(DRAIN_CYCLES) > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [SCW-1:0] STALL_LIMIT = SCW'(MAX_STALL);
   localparam logic [DCW-1:0] DRAIN_LOAD  = DCW'(DRAIN_CYCLES - 1);

   pipe_ctrl_state_e state_q, state_d;
   logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
   logic             halt_err_q, halt_err_d;
   pipe_ctl_t        ctl;
   logic             halt_req;
   logic             run_rules;
   logic             stall_evt;
   logic             flush_evt;

   assign halt_req = if_id_valid_inst & (id_is_ebreak | id_illegal);

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      drain_cnt_d = drain_cnt_q;
      halt_err_d  = halt_err_q;
      ctl         = CTL_HALT;
      run_rules   = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;

      case (state_q)
         ST_INIT: begin
            ctl     = CTL_INIT;
            state_d = ST_RUN;
         end
         ST_RUN: run_rules = 1'b1;
         ST_LDSTALL: begin
            if (ex_take_branch) begin
               ctl       = CTL_BRANCH;
               flush_evt = 1'b1;
               state_d   = ST_RUN;
            end else if (!id_stall_flag) begin
               // Hazard cleared: resume this very cycle rather than spending one idle.
               run_rules = 1'b1;
            end else if (stall_cnt_q < STALL_LIMIT) begin
               ctl         = CTL_STALL;
               stall_evt   = 1'b1;
               stall_cnt_d = stall_cnt_q + SCW'(1);
            end else begin
               ctl        = CTL_STALL;
               stall_evt  = 1'b1;
               halt_err_d = 1'b1;
               state_d    = ST_HALT;
            end
         end
         ST_DRAIN: begin
            ctl         = CTL_DRAIN;
            drain_cnt_d = (drain_cnt_q == '0) ? '0 : drain_cnt_q - DCW'(1);
            if (drain_cnt_q <= DCW'(1)) state_d = ST_HALT;
         end
         ST_HALT: ctl = CTL_HALT;
         default: begin
            ctl     = CTL_INIT;
            state_d = ST_INIT;
         end
      endcase

      if (run_rules) begin
         if (ex_take_branch) begin
            ctl       = CTL_BRANCH;
            flush_evt = 1'b1;
            state_d   = ST_RUN;
         end else if (halt_req) begin
            ctl         = CTL_HALTREQ;
            drain_cnt_d = DRAIN_LOAD;
            state_d     = ST_DRAIN;
            if (id_illegal) halt_err_d = 1'b1;
         end else if (id_stall_flag) begin
            ctl         = CTL_STALL;
            stall_evt   = 1'b1;
            stall_cnt_d = SCW'(1);
            state_d     = ST_LDSTALL;
         end else begin
            ctl     = CTL_NORMAL;
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         stall_cnt_q <= '0;
         drain_cnt_q <= '0;
         halt_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         halt_err_q  <= halt_err_d;
      end
   end

   assign pc_en        = ctl.pc_en;
   assign if_id_en     = ctl.if_id_en;
   assign if_id_flush  = ctl.if_id_flush;
   assign id_ex_en     = ctl.id_ex_en;
   assign id_ex_bubble = ctl.id_ex_bubble;
   assign halted       = (state_q == ST_HALT);
   assign halt_err     = halt_err_q;

`ifdef PIPE_PERF_CNT_EN
   pipe_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .stall_inc    (stall_evt),
      .flush_inc    (flush_evt),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`else
   logic unused_evt;
   assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed + randomized bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

   localparam int MAX_STALL    = 3;
   localparam int DRAIN_CYCLES = 3;

   logic clk = 1'b0;
   logic rst;
   logic if_id_valid_inst, id_stall_flag, id_illegal, id_is_ebreak, ex_take_branch;
   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, halted, halt_err;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   int n_chk = 0;
   int n_bad = 0;

   // Model: pipeline phase tracked as plain flags and countdowns.
   bit          m_init, m_halted, m_err;
   int          m_streak, m_drain;
   bit [31:0]   m_stall, m_flush;
   logic [4:0]  e_ctl;
   logic        e_hlt, e_err;

   always #5 clk = ~clk;

   pipe_ctrl #(.MAX_STALL(MAX_STALL), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_id_valid_inst (if_id_valid_inst),
      .id_stall_flag    (id_stall_flag),
      .id_illegal       (id_illegal),
      .id_is_ebreak     (id_is_ebreak),
      .ex_take_branch   (ex_take_branch),
      .pc_en            (pc_en),
      .if_id_en         (if_id_en),
      .if_id_flush      (if_id_flush),
      .id_ex_en         (id_ex_en),
      .id_ex_bubble     (id_ex_bubble),
      .halted           (halted),
      .halt_err         (halt_err)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles     (stall_cycles),
      .flush_count      (flush_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit v, input bit st, input bit il, input bit eb, input bit br);
      bit hreq;
      hreq  = v & (eb | il);
      e_hlt = m_halted;
      e_err = m_err;
      if (m_init) begin
         e_ctl  = 5'b00111;
         m_init = 1'b0;
      end else if (m_halted) begin
         e_ctl = 5'b00000;
      end else if (m_drain > 0) begin
         e_ctl = 5'b00011;
         m_drain--;
         if (m_drain == 0) m_halted = 1'b1;
      end else if (br) begin
         e_ctl    = 5'b11111;
         m_streak = 0;
         m_flush++;
      end else if (m_streak > 0 && st) begin
         e_ctl = 5'b00011;
         m_stall++;
         if (m_streak < MAX_STALL) m_streak++;
         else begin
            m_err    = 1'b1;
            m_halted = 1'b1;
            m_streak = 0;
         end
      end else if (hreq) begin
         e_ctl    = 5'b00110;
         m_streak = 0;
         m_drain  = DRAIN_CYCLES - 1;
         if (il) m_err = 1'b1;
      end else if (st) begin
         e_ctl    = 5'b00011;
         m_streak = 1;
         m_stall++;
      end else begin
         e_ctl    = 5'b11010;
         m_streak = 0;
      end
   endtask

   task automatic check_outs(input string pfx);
      check({pfx, "_ctl"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble}), 32'(e_ctl));
      check({pfx, "_halted"}, 32'(halted), 32'(e_hlt));
      check({pfx, "_err"}, 32'(halt_err), 32'(e_err));
`ifdef PIPE_PERF_CNT_EN
      check({pfx, "_stall_cycles"}, stall_cycles, m_stall);
      check({pfx, "_flush_count"}, flush_count, m_flush);
`endif
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc(input string tag, input bit v, input bit st, input bit il, input bit eb, input bit br);
      if_id_valid_inst = v;
      id_stall_flag    = st;
      id_illegal       = il;
      id_is_ebreak     = eb;
      ex_take_branch   = br;
      #1;
      model_step(v, st, il, eb, br);
      check_outs(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {if_id_valid_inst, id_stall_flag, id_illegal, id_is_ebreak, ex_take_branch} = 5'b0;
      #1;
      m_init = 1'b0; m_halted = 1'b0; m_err = 1'b0;
      m_streak = 0; m_drain = 0; m_stall = '0; m_flush = '0;
      e_ctl = 5'b00111; e_hlt = 1'b0; e_err = 1'b0;
      check_outs("rst");
      m_init = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {if_id_valid_inst, id_stall_flag, id_illegal, id_is_ebreak, ex_take_branch} = 5'b0;
      @(negedge clk);

      do_reset();
      cyc("init", 1, 0, 0, 0, 0);
      cyc("run0", 1, 0, 0, 0, 0);
      cyc("run1", 1, 0, 0, 0, 0);

      cyc("st2_a", 1, 1, 0, 0, 0);
      cyc("st2_b", 1, 1, 0, 0, 0);
      cyc("st2_rel", 1, 0, 0, 0, 0);
      cyc("st2_run", 1, 0, 0, 0, 0);

      cyc("br_st", 1, 1, 0, 0, 1);
      cyc("br_after", 1, 0, 0, 0, 0);
      cyc("ld_enter", 1, 1, 0, 0, 0);
      cyc("ld_br", 1, 1, 0, 0, 1);
      cyc("ld_enter2", 1, 1, 0, 0, 0);
      cyc("ld_ebreak", 1, 0, 0, 1, 0);
      cyc("drain_a", 0, 0, 0, 0, 1);
      cyc("drain_b", 0, 0, 0, 0, 0);
      cyc("halt_a", 1, 0, 0, 0, 0);
      cyc("halt_b", 1, 1, 1, 0, 1);

      do_reset();
      cyc("init2", 0, 0, 0, 0, 0);
      cyc("ill_req", 1, 0, 1, 0, 0);
      cyc("ill_dr_a", 0, 0, 0, 0, 0);
      cyc("ill_dr_b", 0, 0, 0, 0, 0);
      cyc("ill_halt", 0, 0, 0, 0, 0);

      do_reset();
      cyc("init3", 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc("wdog", 1, 1, 0, 0, 0);

      do_reset();
      cyc("init4", 0, 0, 0, 0, 0);
      cyc("mid_req", 1, 0, 1, 1, 0);
      cyc("mid_drain", 0, 0, 0, 0, 0);
      do_reset();
      cyc("init5", 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 5) == 0))
            do_reset();
         else
            cyc("rnd",
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 10);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
